mem_stage: RTL and testbench
============================

# mem_stage

Memory-access pipeline stage and the consumer of the EX-stage outputs: write-reg/mem-to-reg/write-mem flags, memc code, ALU result, destination register and store value. Non-memory instructions pass through to writeback in one cycle. Loads and stores run a request/grant/response handshake with the data memory, stall the upstream pipeline until they complete, and align data by byte lane.

## Interface
- DATA_W, 32, data/address width
- REG_ADDR_W, 5, register index width
- MEMC_W, 4, memc code width
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- ex_valid  in  1  EX outputs valid this cycle
- ex_write_reg  in  1  instruction writes a register
- ex_mem_to_reg  in  1  load
- ex_write_mem  in  1  store
- ex_memc  in  MEMC_W  access type (MEM_NONE/LB/LBU/LH/LHU/LW/SB/SH/SW)
- ex_alu_result  in  DATA_W  ALU result, or byte address for memory ops
- ex_des_r  in  REG_ADDR_W  destination register
- ex_store_val  in  DATA_W  store data
- mem_stall  out  1  upstream must hold its EX outputs
- dm_req / dm_we  out  1 / 1  memory request / write
- dm_addr  out  DATA_W  word-aligned address ({addr[31:2],2'b00})
- dm_be  out  4  byte enables, bit k = byte lane k
- dm_wdata  out  DATA_W  lane-positioned store data
- dm_gnt  in  1  request accepted
- dm_rvalid / dm_rdata  in  1 / DATA_W  load response
- wb_valid / wb_write_reg  out  1 / 1  writeback valid / write enable
- wb_des_r / wb_data  out  REG_ADDR_W / DATA_W  writeback target / data
- mem_misalign  out  1  one-cycle misaligned-access pulse

## Operation
- FSM states: IDLE, REQ, WAIT.
- IDLE, ex_valid=1, no memory op: register wb_* on the next edge. wb_data = ex_alu_result; stay in IDLE.
- IDLE, memory op: latch address, type, des_r and data, then go to REQ. A store is ex_write_mem=1. A load is ex_mem_to_reg=1. If both flags are set, the op is a store.
- REQ: drive dm_req=1 and hold addr/be/we/wdata stable until dm_gnt=1.
  - Store with grant: go to IDLE and pulse wb_valid=1 with wb_write_reg=0.
  - Load with grant: go to WAIT.
- WAIT: on dm_rvalid=1, register wb_data, wb_write_reg=1, wb_valid=1, then go to IDLE.
- dm_rvalid outside WAIT is ignored. A responder never returns rvalid in the same cycle as gnt.
- Byte lane: lane = addr[1:0], little-endian.
  - Load extraction: LB/LBU take rdata[8·lane+7:8·lane], sign-/zero-extended. LH/LHU take the half selected by addr[1], sign-/zero-extended. LW takes the full word.
  - Store placement: SB replicates the byte to all lanes with be = 1<<lane. SH replicates the half with be = 0011 (addr[1]=0) or 1100. SW uses be=1111.
- mem_stall = (state != IDLE). Inputs are ignored while mem_stall=1.
- ex_valid=0 in IDLE: wb_valid=0 next cycle.

## Timing
- Reset values: state IDLE, mem_stall 0, dm_req 0, dm_we 0, dm_addr 0, dm_be 0, dm_wdata 0, wb_valid 0, wb_write_reg 0, wb_des_r 0, wb_data 0, mem_misalign 0.
- Pass-through latency: 1 cycle.
- Store latency: accept at T, dm_req from T+1, wb_valid at the cycle after the grant (T+2 minimum).
- Load latency: accept at T, dm_req T+1, gnt at T+1, rvalid at T+2 or later, wb_valid one cycle after rvalid (T+3 minimum).
- wb_valid is a single-cycle pulse per instruction.
- Reset asserted in REQ or WAIT: state returns to IDLE and dm_req drops on the same edge. An in-flight response is discarded and produces no wb_valid.
- Back-to-back memory ops: the next op is accepted in the first IDLE cycle after completion.

## Configuration
- MEM_ALIGN_CHECK_EN defined: misalignment is LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠0. A misaligned op:
  - issues no dm_req and stays in IDLE;
  - pulses mem_misalign=1 and wb_valid=1 with wb_write_reg=0, one cycle after accept.
- Not defined: mem_misalign is tied 0. Low address bits are dropped: halfword uses addr[1] only, word ignores addr[1:0].

## Structure
- Shared package: DATA_W/REG_ADDR_W/MEMC_W defaults, memc code constants (MEM_NONE=0, LB, LBU, LH, LHU, LW, SB, SH, SW), FSM state encoding.
- Sub-module mem_align: combinational load extraction/extension and store lane placement/byte-enable generation. Shared by the load and store paths.

## Test plan
- ALU op, ex_alu_result=0x1234_5678, des_r=5 → next cycle wb_valid=1, wb_write_reg=1, wb_des_r=5, wb_data=0x1234_5678, mem_stall=0.
- LB at 0x103, rdata=0x80AA_BBCC, gnt immediate, rvalid 1 cycle later → dm_addr=0x100, wb_data=0xFFFF_FF80 at T+3. LBU at the same address → 0x0000_0080.
- SH at 0x202, store_val=0x0000_BEEF, gnt held low 3 cycles → dm_req and dm_addr=0x200 held stable, dm_be=1100, dm_wdata=0xBEEF_BEEF, mem_stall=1 throughout, wb_write_reg=0.
- rst_n=0 in WAIT, then rvalid arrives → state IDLE, all outputs at reset values, no wb_valid.
- LW at 0x301: with MEM_ALIGN_CHECK_EN → no dm_req, mem_misalign pulse. Without it → dm_addr=0x300, normal load.
- LH at 0x402 followed by SW at 0x500 back-to-back → second op accepted the cycle after the first op's wb_valid, no overlap on dm_req.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared widths, memory-access codes and FSM encoding for the memory pipeline stage.
package mem_stage_pkg;

    localparam int DEF_DATA_W     = 32;
    localparam int DEF_REG_ADDR_W = 5;
    localparam int DEF_MEMC_W     = 4;

    localparam logic [DEF_MEMC_W-1:0] MEM_NONE = 4'd0;
    localparam logic [DEF_MEMC_W-1:0] MEM_LB   = 4'd1;
    localparam logic [DEF_MEMC_W-1:0] MEM_LBU  = 4'd2;
    localparam logic [DEF_MEMC_W-1:0] MEM_LH   = 4'd3;
    localparam logic [DEF_MEMC_W-1:0] MEM_LHU  = 4'd4;
    localparam logic [DEF_MEMC_W-1:0] MEM_LW   = 4'd5;
    localparam logic [DEF_MEMC_W-1:0] MEM_SB   = 4'd6;
    localparam logic [DEF_MEMC_W-1:0] MEM_SH   = 4'd7;
    localparam logic [DEF_MEMC_W-1:0] MEM_SW   = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

    // Halfwords must sit on even addresses, words on multiples of four.
    function automatic logic misaligned(input logic [DEF_MEMC_W-1:0] memc,
                                        input logic [1:0]            lane);
        case (memc)
            MEM_LH, MEM_LHU, MEM_SH: return lane[0];
            MEM_LW, MEM_SW:          return |lane;
            default:                 return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_align.sv
// Byte-lane steering: load extraction with sign/zero extension, store replication and byte enables.
module mem_align
    import mem_stage_pkg::*;
(
    input  logic [DEF_MEMC_W-1:0] ld_memc_i,
    input  logic [1:0]            ld_lane_i,
    input  logic [DEF_DATA_W-1:0] ld_rdata_i,
    output logic [DEF_DATA_W-1:0] ld_data_o,
    input  logic [DEF_MEMC_W-1:0] st_memc_i,
    input  logic [1:0]            st_lane_i,
    input  logic [DEF_DATA_W-1:0] st_val_i,
    output logic [DEF_DATA_W-1:0] st_wdata_o,
    output logic [3:0]            st_be_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = ld_rdata_i[{ld_lane_i, 3'b000} +: 8];
    assign half_sel = ld_rdata_i[{ld_lane_i[1], 4'b0000} +: 16];

    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned and infers a latch.
    always_comb begin
        ld_data_o = ld_rdata_i;
        case (ld_memc_i)
            MEM_LB:  ld_data_o = {{24{byte_sel[7]}}, byte_sel};
            MEM_LBU: ld_data_o = {24'd0, byte_sel};
            MEM_LH:  ld_data_o = {{16{half_sel[15]}}, half_sel};
            MEM_LHU: ld_data_o = {16'd0, half_sel};
            default: ld_data_o = ld_rdata_i;
        endcase
    end

    // Stores replicate the datum across lanes so the memory only needs the byte enables.
    always_comb begin
        st_wdata_o = st_val_i;
        st_be_o    = 4'b0000;
        case (st_memc_i)
            MEM_SB: begin
                st_wdata_o = {4{st_val_i[7:0]}};
                st_be_o    = 4'b0001 << st_lane_i;
            end
            MEM_SH: begin
                st_wdata_o = {2{st_val_i[15:0]}};
                st_be_o    = st_lane_i[1] ? 4'b1100 : 4'b0011;
            end
            MEM_SW:  st_be_o = 4'b1111;
            default: st_be_o = 4'b0000;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: pass-through to writeback, or a req/gnt/rvalid data-memory access.
// Optional misaligned-access trapping is enabled by defining MEM_ALIGN_CHECK_EN.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int REG_ADDR_W = DEF_REG_ADDR_W,
    parameter int MEMC_W     = DEF_MEMC_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ex_valid,
    input  logic                  ex_write_reg,
    input  logic                  ex_mem_to_reg,
    input  logic                  ex_write_mem,
    input  logic [MEMC_W-1:0]     ex_memc,
    input  logic [DATA_W-1:0]     ex_alu_result,
    input  logic [REG_ADDR_W-1:0] ex_des_r,
    input  logic [DATA_W-1:0]     ex_store_val,
    output logic                  mem_stall,
    output logic                  dm_req,
    output logic                  dm_we,
    output logic [DATA_W-1:0]     dm_addr,
    output logic [3:0]            dm_be,
    output logic [DATA_W-1:0]     dm_wdata,
    input  logic                  dm_gnt,
    input  logic                  dm_rvalid,
    input  logic [DATA_W-1:0]     dm_rdata,
    output logic                  wb_valid,
    output logic                  wb_write_reg,
    output logic [REG_ADDR_W-1:0] wb_des_r,
    output logic [DATA_W-1:0]     wb_data,
    output logic                  mem_misalign
);

    state_e                state_q, state_d;
    logic [DATA_W-1:0]     addr_q, addr_d;
    logic [MEMC_W-1:0]     memc_q, memc_d;
    logic [REG_ADDR_W-1:0] des_r_q, des_r_d;
    logic                  is_store_q, is_store_d;
    logic [3:0]            be_q, be_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic                  wb_valid_q, wb_valid_d;
    logic                  wb_write_reg_q, wb_write_reg_d;
    logic [REG_ADDR_W-1:0] wb_des_r_q, wb_des_r_d;
    logic [DATA_W-1:0]     wb_data_q, wb_data_d;
    logic                  misalign_q, misalign_d;

    logic [DATA_W-1:0] ld_data;
    logic [DATA_W-1:0] st_wdata;
    logic [3:0]        st_be;
    logic              is_mem_op;
    logic              bad_align;

    mem_align u_align (
        .ld_memc_i  (memc_q),
        .ld_lane_i  (addr_q[1:0]),
        .ld_rdata_i (dm_rdata),
        .ld_data_o  (ld_data),
        .st_memc_i  (ex_memc),
        .st_lane_i  (ex_alu_result[1:0]),
        .st_val_i   (ex_store_val),
        .st_wdata_o (st_wdata),
        .st_be_o    (st_be)
    );

    assign is_mem_op = ex_write_mem | ex_mem_to_reg;

`ifdef MEM_ALIGN_CHECK_EN
    assign bad_align = misaligned(ex_memc, ex_alu_result[1:0]);
`else
    assign bad_align = 1'b0;
`endif

    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        memc_d         = memc_q;
        des_r_d        = des_r_q;
        is_store_d     = is_store_q;
        be_d           = be_q;
        wdata_d        = wdata_q;
        wb_valid_d     = 1'b0;
        wb_write_reg_d = wb_write_reg_q;
        wb_des_r_d     = wb_des_r_q;
        wb_data_d      = wb_data_q;
        misalign_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (ex_valid) begin
                    if (!is_mem_op) begin
                        wb_valid_d     = 1'b1;
                        wb_write_reg_d = ex_write_reg;
                        wb_des_r_d     = ex_des_r;
                        wb_data_d      = ex_alu_result;
                    end else if (bad_align) begin
                        wb_valid_d     = 1'b1;
                        wb_write_reg_d = 1'b0;
                        wb_des_r_d     = ex_des_r;
                        misalign_d     = 1'b1;
                    end else begin
                        // A set store flag wins over the load flag.
                        addr_d     = ex_alu_result;
                        memc_d     = ex_memc;
                        des_r_d    = ex_des_r;
                        is_store_d = ex_write_mem;
                        be_d       = ex_write_mem ? st_be : 4'b1111;
                        wdata_d    = st_wdata;
                        state_d    = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                if (dm_gnt) begin
                    if (is_store_q) begin
                        wb_valid_d     = 1'b1;
                        wb_write_reg_d = 1'b0;
                        wb_des_r_d     = des_r_q;
                        state_d        = ST_IDLE;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (dm_rvalid) begin
                    wb_valid_d     = 1'b1;
                    wb_write_reg_d = 1'b1;
                    wb_des_r_d     = des_r_q;
                    wb_data_d      = ld_data;
                    state_d        = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: datapath registers are reset along with the FSM because they drive the dm_* and wb_* ports directly.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            addr_q         <= '0;
            memc_q         <= MEM_NONE;
            des_r_q        <= '0;
            is_store_q     <= 1'b0;
            be_q           <= 4'b0000;
            wdata_q        <= '0;
            wb_valid_q     <= 1'b0;
            wb_write_reg_q <= 1'b0;
            wb_des_r_q     <= '0;
            wb_data_q      <= '0;
            misalign_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge value of the others.
            state_q        <= state_d;
            addr_q         <= addr_d;
            memc_q         <= memc_d;
            des_r_q        <= des_r_d;
            is_store_q     <= is_store_d;
            be_q           <= be_d;
            wdata_q        <= wdata_d;
            wb_valid_q     <= wb_valid_d;
            wb_write_reg_q <= wb_write_reg_d;
            wb_des_r_q     <= wb_des_r_d;
            wb_data_q      <= wb_data_d;
            misalign_q     <= misalign_d;
        end
    end

    assign mem_stall    = (state_q != ST_IDLE);
    assign dm_req       = (state_q == ST_REQ);
    assign dm_we        = dm_req & is_store_q;
    assign dm_addr      = {addr_q[DATA_W-1:2], 2'b00};
    assign dm_be        = be_q;
    assign dm_wdata     = wdata_q;
    assign wb_valid     = wb_valid_q;
    assign wb_write_reg = wb_write_reg_q;
    assign wb_des_r     = wb_des_r_q;
    assign wb_data      = wb_data_q;
    assign mem_misalign = misalign_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios, then randomized ops against an arithmetic reference model.
module tb_mem_stage;

    localparam int C_NONE = 0, C_LB = 1, C_LBU = 2, C_LH = 3, C_LHU = 4, C_LW = 5;
    localparam int C_SB = 6, C_SH = 7, C_SW = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid, ex_write_reg, ex_mem_to_reg, ex_write_mem;
    logic [3:0]  ex_memc;
    logic [31:0] ex_alu_result, ex_store_val;
    logic [4:0]  ex_des_r;
    logic        mem_stall, dm_req, dm_we;
    logic [31:0] dm_addr, dm_wdata;
    logic [3:0]  dm_be;
    logic        dm_gnt, dm_rvalid;
    logic [31:0] dm_rdata;
    logic        wb_valid, wb_write_reg;
    logic [4:0]  wb_des_r;
    logic [31:0] wb_data;
    logic        mem_misalign;

    int checks = 0;
    int errors = 0;

    mem_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ex_valid      (ex_valid),
        .ex_write_reg  (ex_write_reg),
        .ex_mem_to_reg (ex_mem_to_reg),
        .ex_write_mem  (ex_write_mem),
        .ex_memc       (ex_memc),
        .ex_alu_result (ex_alu_result),
        .ex_des_r      (ex_des_r),
        .ex_store_val  (ex_store_val),
        .mem_stall     (mem_stall),
        .dm_req        (dm_req),
        .dm_we         (dm_we),
        .dm_addr       (dm_addr),
        .dm_be         (dm_be),
        .dm_wdata      (dm_wdata),
        .dm_gnt        (dm_gnt),
        .dm_rvalid     (dm_rvalid),
        .dm_rdata      (dm_rdata),
        .wb_valid      (wb_valid),
        .wb_write_reg  (wb_write_reg),
        .wb_des_r      (wb_des_r),
        .wb_data       (wb_data),
        .mem_misalign  (mem_misalign)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_load(input int code, input logic [31:0] addr,
                                             input logic [31:0] rd);
        int          lane = int'(addr[1:0]);
        logic [31:0] v;
        case (code)
            C_LB, C_LBU: begin
                v = (rd >> (8 * lane)) & 32'hFF;
                if (code == C_LB && v >= 32'd128) v = v - 32'd256;
            end
            C_LH, C_LHU: begin
                v = (rd >> (16 * (lane / 2))) & 32'hFFFF;
                if (code == C_LH && v >= 32'd32768) v = v - 32'd65536;
            end
            default: v = rd;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] ref_be(input int code, input logic [31:0] addr);
        int lane = int'(addr[1:0]);
        case (code)
            C_SB:    return 32'(1 << lane);
            C_SH:    return (lane >= 2) ? 32'd12 : 32'd3;
            default: return 32'd15;
        endcase
    endfunction

    function automatic logic [31:0] ref_wdata(input int code, input logic [31:0] sv);
        case (code)
            C_SB:    return (sv & 32'hFF) * 32'h0101_0101;
            C_SH:    return (sv & 32'hFFFF) * 32'h0001_0001;
            default: return sv;
        endcase
    endfunction

    function automatic bit ref_misaligned(input int code, input logic [31:0] addr);
`ifdef MEM_ALIGN_CHECK_EN
        if (code == C_LH || code == C_LHU || code == C_SH) return (addr % 2) != 0;
        if (code == C_LW || code == C_SW) return (addr % 4) != 0;
`endif
        return 1'b0;
    endfunction

    task automatic drive_garbage();
        ex_valid      = 1'($urandom_range(0, 1));
        ex_write_reg  = 1'($urandom_range(0, 1));
        ex_mem_to_reg = 1'($urandom_range(0, 1));
        ex_write_mem  = 1'($urandom_range(0, 1));
        ex_memc       = 4'($urandom_range(0, 8));
        ex_alu_result = $urandom;
        ex_des_r      = 5'($urandom);
        ex_store_val  = $urandom;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_stall"}, 32'(mem_stall), 0);
        check({tag, "_req"}, 32'(dm_req), 0);
        check({tag, "_we"}, 32'(dm_we), 0);
        check({tag, "_addr"}, dm_addr, 0);
        check({tag, "_be"}, 32'(dm_be), 0);
        check({tag, "_wdata"}, dm_wdata, 0);
        check({tag, "_wbv"}, 32'(wb_valid), 0);
        check({tag, "_wbwr"}, 32'(wb_write_reg), 0);
        check({tag, "_wbdes"}, 32'(wb_des_r), 0);
        check({tag, "_wbdata"}, wb_data, 0);
        check({tag, "_mis"}, 32'(mem_misalign), 0);
    endtask

    task automatic alu_op(input logic [4:0] des, input logic [31:0] res, input logic wr);
        ex_valid = 1'b1; ex_write_reg = wr; ex_mem_to_reg = 1'b0; ex_write_mem = 1'b0;
        ex_memc = 4'(C_NONE); ex_alu_result = res; ex_des_r = des; ex_store_val = $urandom;
        tick();
        ex_valid = 1'b0;
        check("alu_wbv", 32'(wb_valid), 1);
        check("alu_wbwr", 32'(wb_write_reg), 32'(wr));
        check("alu_des", 32'(wb_des_r), 32'(des));
        check("alu_data", wb_data, res);
        check("alu_stall", 32'(mem_stall), 0);
        check("alu_req", 32'(dm_req), 0);
    endtask

    // Accept edge through writeback pulse; returns sampled in the writeback cycle.
    task automatic mem_op(input int code, input logic [31:0] addr, input logic [31:0] sv,
                          input logic [31:0] rd, input logic [4:0] des,
                          input int gnt_dly, input int rv_dly);
        logic is_st = (code >= C_SB);
        ex_valid = 1'b1; ex_memc = 4'(code); ex_alu_result = addr; ex_store_val = sv;
        ex_des_r = des; ex_write_mem = is_st; ex_write_reg = !is_st;
        ex_mem_to_reg = is_st ? 1'($urandom_range(0, 1)) : 1'b1;
        tick();
        if (ref_misaligned(code, addr)) begin
            ex_valid = 1'b0;
            check("mis_pulse", 32'(mem_misalign), 1);
            check("mis_wbv", 32'(wb_valid), 1);
            check("mis_wbwr", 32'(wb_write_reg), 0);
            check("mis_req", 32'(dm_req), 0);
            check("mis_stall", 32'(mem_stall), 0);
            tick();
            check("mis_end", 32'(mem_misalign), 0);
            check("mis_wbv_end", 32'(wb_valid), 0);
            return;
        end
        for (int i = 0; i <= gnt_dly; i++) begin
            if (i > 0) tick();
            check("req_req", 32'(dm_req), 1);
            check("req_stall", 32'(mem_stall), 1);
            check("req_addr", dm_addr, addr & 32'hFFFF_FFFC);
            check("req_we", 32'(dm_we), 32'(is_st));
            check("req_wbv", 32'(wb_valid), 0);
            check("req_mis", 32'(mem_misalign), 0);
            if (is_st) begin
                check("req_be", 32'(dm_be), ref_be(code, addr));
                check("req_wdata", dm_wdata, ref_wdata(code, sv));
            end
            drive_garbage();
            dm_rvalid = 1'($urandom_range(0, 1));
            dm_rdata  = $urandom;
        end
        dm_gnt = 1'b1; dm_rvalid = 1'b0;
        tick();
        dm_gnt = 1'b0;
        if (is_st) begin
            ex_valid = 1'b0;
            check("st_wbv", 32'(wb_valid), 1);
            check("st_wbwr", 32'(wb_write_reg), 0);
            check("st_req", 32'(dm_req), 0);
            check("st_stall", 32'(mem_stall), 0);
            return;
        end
        for (int i = 0; i <= rv_dly; i++) begin
            if (i > 0) tick();
            check("wait_req", 32'(dm_req), 0);
            check("wait_stall", 32'(mem_stall), 1);
            check("wait_wbv", 32'(wb_valid), 0);
        end
        dm_rvalid = 1'b1; dm_rdata = rd;
        tick();
        dm_rvalid = 1'b0; dm_rdata = $urandom; ex_valid = 1'b0;
        check("ld_wbv", 32'(wb_valid), 1);
        check("ld_wbwr", 32'(wb_write_reg), 1);
        check("ld_des", 32'(wb_des_r), 32'(des));
        check("ld_data", wb_data, ref_load(code, addr, rd));
        check("ld_stall", 32'(mem_stall), 0);
        check("ld_req", 32'(dm_req), 0);
    endtask

    initial begin
        rst_n = 1'b0; dm_gnt = 1'b0; dm_rvalid = 1'b0; dm_rdata = '0;
        drive_garbage();
        tick(); tick();
        check_reset_state("rst");
        rst_n = 1'b1; ex_valid = 1'b0;

        // Pass-through and idle bubble
        alu_op(5'd5, 32'h1234_5678, 1'b1);
        tick();
        check("bubble_wbv", 32'(wb_valid), 0);

        // Byte loads with sign and zero extension
        mem_op(C_LB, 32'h103, 0, 32'h80AA_BBCC, 5'd7, 0, 0);
        mem_op(C_LBU, 32'h103, 0, 32'h80AA_BBCC, 5'd8, 0, 0);

        // Halfword store with grant withheld
        mem_op(C_SH, 32'h202, 32'h0000_BEEF, 0, 5'd0, 3, 0);

        // Misaligned word load (trapped or dropped low bits depending on build)
        mem_op(C_LW, 32'h301, 0, 32'hCAFE_F00D, 5'd9, 0, 1);

        // Back-to-back memory ops
        mem_op(C_LH, 32'h402, 0, 32'h8001_7FFF, 5'd10, 1, 0);
        mem_op(C_SW, 32'h500, 32'hDEAD_BEEF, 0, 5'd0, 0, 0);
        tick();
        check("b2b_idle_wbv", 32'(wb_valid), 0);

        // Reset while waiting for the load response
        ex_valid = 1'b1; ex_memc = 4'(C_LW); ex_alu_result = 32'h600; ex_des_r = 5'd3;
        ex_write_mem = 1'b0; ex_mem_to_reg = 1'b1; ex_write_reg = 1'b1;
        tick();
        ex_valid = 1'b0; dm_gnt = 1'b1;
        tick();
        dm_gnt = 1'b0;
        check("rw_stall", 32'(mem_stall), 1);
        rst_n = 1'b0;
        tick();
        check_reset_state("rst_wait");
        rst_n = 1'b1; dm_rvalid = 1'b1; dm_rdata = 32'h1111_2222;
        tick();
        dm_rvalid = 1'b0;
        check("rw_late_wbv", 32'(wb_valid), 0);
        check("rw_late_stall", 32'(mem_stall), 0);

        // Reset while requesting a store
        ex_valid = 1'b1; ex_memc = 4'(C_SW); ex_alu_result = 32'h700; ex_store_val = 32'h5555_AAAA;
        ex_write_mem = 1'b1; ex_mem_to_reg = 1'b0; ex_write_reg = 1'b0;
        tick();
        ex_valid = 1'b0;
        check("rr_req", 32'(dm_req), 1);
        rst_n = 1'b0;
        tick();
        check_reset_state("rst_req");
        rst_n = 1'b1;
        tick();

        // Randomized mix
        for (int n = 0; n < 80; n++) begin
            int code = $urandom_range(0, 8);
            if (code == C_NONE) begin
                alu_op(5'($urandom), $urandom, 1'($urandom_range(0, 1)));
            end else begin
                mem_op(code, $urandom, $urandom, $urandom, 5'($urandom),
                       $urandom_range(0, 3), $urandom_range(0, 2));
            end
            if ($urandom_range(0, 3) == 0) begin
                tick();
                check("rnd_bubble_wbv", 32'(wb_valid), 0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
